// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the pipelined OTTER core and its
// hazard scoreboard.
package otter_pkg;

  // RV32I major opcodes decoded by the core.
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  // Branch condition selected by funct3.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_t;

  // EX operand source; encoding matches the existing operand mux.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_t;

  // Default result latencies as seen by a dependent instruction in decode.
  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

  // The younger EX/MEM result takes precedence over MEM/WB.
  function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_NONE;
  endfunction

endpackage

// File: rtl/otter_sb_array.sv
// otter_sb_array: one countdown counter per architectural register giving the
// cycles until its pending result can be forwarded into EX. Entry 0 is always 0.
module otter_sb_array
  import otter_pkg::*;
#(
  parameter  int NREG  = 32,
  parameter  int LAT_W = 3,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             dec_en_i,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic [LAT_W-1:0] set_val_i,
  input  logic [AW-1:0]    rs1_addr_i,
  input  logic [AW-1:0]    rs2_addr_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [LAT_W-1:0] rs1_cnt_o,
  output logic [LAT_W-1:0] rs2_cnt_o,
  output logic [LAT_W-1:0] rd_cnt_o
);

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  // Age every pending entry by one; a new issue then overrides its own slot.
  always_comb begin
    // NOTE: assign the default first so every path drives cnt_d and no latch is inferred.
    // NOTE: blocking (=) here because this block is combinational; later lines see earlier ones.
    cnt_d = cnt_q;
    if (dec_en_i) begin
      for (int r = 1; r < NREG; r++) begin
        cnt_d[r] = (cnt_q[r] == '0) ? '0 : cnt_q[r] - LAT_W'(1);
      end
      if (set_en_i) begin
        cnt_d[set_addr_i] = set_val_i;
      end
    end
    cnt_d[0] = '0;
  end

  // Counter storage; RESET drops every pending result at once.
  always_ff @(posedge CLK or posedge RESET) begin
    // NOTE: the array is built from flops, not a RAM macro, so clearing it on reset is legal and required.
    if (RESET) begin
      cnt_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking (<=) for state so every flop samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

  assign rs1_cnt_o = cnt_q[rs1_addr_i];
  assign rs2_cnt_o = cnt_q[rs2_addr_i];
  assign rd_cnt_o  = cnt_q[rd_addr_i];

endmodule

// File: rtl/otter_hazard_scoreboard.sv
// otter_hazard_scoreboard: decode/execute hazard controller for the pipelined
// OTTER core. Drives stall/bubble/flush enables from the latency scoreboard,
// EX forwarding selects, and saturating stall/flush performance counters.
module otter_hazard_scoreboard
  import otter_pkg::*;
#(
  parameter  int NREG    = 32,
  parameter  int LAT_W   = 3,
  parameter  int MAX_LAT = 7,
  parameter  int CNT_W   = 32,
  localparam int AW      = $clog2(NREG)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_rd_used,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic [AW-1:0]    ex_rs1,
  input  logic [AW-1:0]    ex_rs2,
  input  logic [AW-1:0]    mem_rd,
  input  logic [AW-1:0]    wb_rd,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             mem_is_load,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [LAT_W-1:0] lat_c;
  logic [LAT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt;
  logic [LAT_W:0]   waw_limit;
  logic             raw, waw, issue, set_en;
  logic             mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  // Over-long latencies are clamped; one spare bit keeps lat_c+1 from wrapping.
  assign lat_c     = (int'(id_lat) > MAX_LAT) ? LAT_W'(MAX_LAT) : id_lat;
  assign waw_limit = {1'b0, lat_c} + (LAT_W+1)'(1);

  otter_sb_array #(
    .NREG  (NREG),
    .LAT_W (LAT_W)
  ) u_sb_array (
    .CLK        (CLK),
    .RESET      (RESET),
    .dec_en_i   (~mem_busy),
    .set_en_i   (set_en),
    .set_addr_i (id_rd),
    .set_val_i  (lat_c),
    .rs1_addr_i (id_rs1),
    .rs2_addr_i (id_rs2),
    .rd_addr_i  (id_rd),
    .rs1_cnt_o  (rs1_cnt),
    .rs2_cnt_o  (rs2_cnt),
    .rd_cnt_o   (rd_cnt)
  );

  // A WAW hazard exists only if the older write would land after the new one.
  assign raw    = id_valid & ((id_rs1_used & (rs1_cnt != '0)) | (id_rs2_used & (rs2_cnt != '0)));
  assign waw    = id_valid & id_rd_used & (id_rd != '0) & ({1'b0, rd_cnt} > waw_limit);
  assign stall  = (raw | waw) & ~ex_redirect;
  assign issue  = id_valid & ~stall & ~ex_redirect & ~mem_busy;
  assign set_en = issue & id_rd_used & (id_rd != '0);

  // Pipeline enables, priority mem_busy > ex_redirect > stall > normal.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Loads in EX/MEM are never forwarded; load-use is resolved by the stall.
  assign mem_hit_a = mem_wr & (mem_rd != '0) & (mem_rd == ex_rs1) & ~mem_is_load;
  assign mem_hit_b = mem_wr & (mem_rd != '0) & (mem_rd == ex_rs2) & ~mem_is_load;
  assign wb_hit_a  = wb_wr & (wb_rd != '0) & (wb_rd == ex_rs1);
  assign wb_hit_b  = wb_wr & (wb_rd != '0) & (wb_rd == ex_rs2);
  assign fwd_a     = fwd_select(mem_hit_a, wb_hit_a);
  assign fwd_b     = fwd_select(mem_hit_b, wb_hit_b);

  // Saturating event counters, frozen while memory is busy.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!mem_busy) begin
      if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (ex_redirect && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
